fp16_add_seq: RTL
=================

FP16_ADD_SEQ -- requirements
Module: fp16_add_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request; sampled only in IDLE
- a  in  16  IEEE-754 half operand A
- b  in  16  IEEE-754 half operand B
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- result  out  16  sum; held stable from DONE until the next accepted start

Function
REQ-003 The FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND (macro only) and DONE; the state SHALL advance exactly once per clk.
REQ-004 In IDLE with start=1, the block SHALL latch a and b and leave IDLE on that edge; start in any other state SHALL be ignored, including in DONE.
REQ-005 On load, an operand with exponent 0 SHALL be treated as zero (flush), and mantissa registers SHALL be 14 bits: hidden bit, 10 fraction bits, then guard, round and sticky.
REQ-006 On load, the operand with the larger exponent SHALL become A, with ties kept in original order, and align count = exponent difference clamped to 14.
REQ-007 On load, if |a|==|b| with opposite signs, result SHALL be 0x0000 and next state DONE.
REQ-008 On load, if either exponent is 31: NaN, or inf plus opposite-sign inf, SHALL give 0x7E00; otherwise the infinity operand SHALL be passed through. Next state DONE.
REQ-009 ALIGN, count>0: B mantissa SHALL shift right 1, OR-ing the bits shifted out into sticky, and count SHALL decrement by 1.
REQ-010 ALIGN, count==0: next state SHALL be ADD.
REQ-011 ADD, one cycle, 15-bit result:
- equal signs: mantissas added;
- opposite signs: smaller magnitude subtracted from larger;
- result sign = sign of the larger-magnitude operand.
REQ-012 NORM SHALL perform one action per cycle:
- carry set: shift right 1 (sticky retained), exponent+1;
- else hidden=0 and exponent>1: shift left 1, exponent-1;
- else: advance to ROUND (macro) or DONE.
REQ-013 A zero sum SHALL give 0x0000. An exponent reaching 31 SHALL give a signed infinity (0x7C00/0xFC00). An exponent reaching 1 with hidden=0 SHALL flush to signed zero.
REQ-014 done SHALL be high only in DONE (exactly one cycle), and DONE SHALL always return to IDLE.
REQ-015 result SHALL update only on the edge entering DONE.

Reset
REQ-016 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0x0000 and clear all internal registers, including mid-operation; no done pulse SHALL follow.
REQ-017 The first start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-018 With FP16_ADD_SEQ_ROUND_EN defined, NORM SHALL go to ROUND, a one-cycle state applying round-to-nearest-even from guard/round/sticky.
REQ-019 If rounding overflows the mantissa, ROUND SHALL shift right 1 and increment the exponent; reaching 31 SHALL give infinity.
REQ-020 Without FP16_ADD_SEQ_ROUND_EN, ROUND SHALL be absent, guard/round/sticky SHALL be discarded (truncation), and NORM SHALL go directly to DONE.

Verification
REQ-021 0x3C00+0x3C00, start at edge T0 -> ALIGN T1, ADD T2, NORM T3-T4, done high in T5 (T6 with macro), result=0x4000.
REQ-022 0x3C00+0xBC00 -> done high in the cycle after the start edge, result=0x0000; 0x7C00+0xFC00 -> 0x7E00.
REQ-023 0x3C00+0x3800 -> exactly one ALIGN shift, result=0x3E00; 0x7BFF+0x7BFF -> 0x7C00.
REQ-024 0x3C00+0xBBFF -> 11 left-normalize cycles, result=0x1000.
REQ-025 start pulsed while busy with different operands -> ignored; first result unchanged and exactly one done pulse.
REQ-026 rst_n low during ALIGN -> busy=0, done=0, result=0x0000 asynchronously, no done afterward; the next start completes normally.

Source files
------------

// File: rtl/fp16_add_seq.sv
// ============================================================================
//  Module   : fp16_add_seq
//  Purpose  : Multi-cycle IEEE-754 half-precision adder. It aligns the smaller
//             operand one bit per cycle, adds or subtracts in one cycle, then
//             normalizes one bit per cycle. Subnormal inputs and results are
//             flushed to zero.
//  Options  : FP16_ADD_SEQ_ROUND_EN - adds a ROUND state that applies
//             round-to-nearest-even. When it is undefined, the guard, round
//             and sticky bits are truncated.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp16_add_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

`ifdef FP16_ADD_SEQ_ROUND_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd5
    } state_t;
`endif

    state_t      state_q, state_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        sign_r_q, sign_r_d;
    logic [4:0]  exp_q, exp_d;
    logic [13:0] man_a_q, man_a_d;      // {hidden, fraction[9:0], guard, round, sticky}
    logic [13:0] man_b_q, man_b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] sum_q, sum_d;          // bit 14 is the add carry
    logic [15:0] result_q, result_d;

    // Operand decode used on the accepting edge
    logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic        w_special, w_cancel, w_b_bigger;
    logic [15:0] w_special_res;
    logic [13:0] w_man_a, w_man_b;
    logic [4:0]  w_diff;
    logic [3:0]  w_cnt_ld;
    logic [15:0] w_pack;

`ifdef FP16_ADD_SEQ_ROUND_EN
    logic        w_round_up;
    logic [11:0] w_round_man;
    logic [4:0]  w_round_exp;
`endif

    // Classify the incoming operands and compute the load-time values
    always_comb begin
        w_a_inf    = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
        w_b_inf    = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
        w_a_nan    = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
        w_b_nan    = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
        w_special  = (a[14:10] == 5'd31) || (b[14:10] == 5'd31);
        w_cancel   = (a[14:0] == b[14:0]) && (a[15] != b[15]);
        w_b_bigger = (b[14:10] > a[14:10]);
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[15] != b[15]))) begin
            w_special_res = 16'h7E00;
        end else if (a[14:10] == 5'd31) begin
            w_special_res = a;
        end else begin
            w_special_res = b;
        end
        // A zero exponent means the operand is treated as zero
        w_man_a  = (a[14:10] == 5'd0) ? 14'd0 : {1'b1, a[9:0], 3'b000};
        w_man_b  = (b[14:10] == 5'd0) ? 14'd0 : {1'b1, b[9:0], 3'b000};
        w_diff   = w_b_bigger ? (b[14:10] - a[14:10]) : (a[14:10] - b[14:10]);
        w_cnt_ld = (w_diff > 5'd14) ? 4'd14 : w_diff[3:0];
    end

    // Pack the normalized sum into the final half-precision word
    always_comb begin
        w_pack = 16'h0000;
`ifdef FP16_ADD_SEQ_ROUND_EN
        w_round_up  = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        w_round_man = {1'b0, sum_q[13:3]} + {11'd0, w_round_up};
        w_round_exp = exp_q + 5'd1;
`endif
        if (sum_q == 15'd0) begin
            w_pack = 16'h0000;
        end else if (exp_q == 5'd31) begin
            w_pack = {sign_r_q, 15'h7C00};
        end else if (!sum_q[13]) begin
            // Underflow after left normalization stopped at exponent 1
            w_pack = {sign_r_q, 15'h0000};
        end else begin
`ifdef FP16_ADD_SEQ_ROUND_EN
            if (w_round_man[11]) begin
                // A rounding carry out leaves the mantissa at 1.0, so the exponent goes up by one
                if (w_round_exp == 5'd31) begin
                    w_pack = {sign_r_q, 15'h7C00};
                end else begin
                    w_pack = {sign_r_q, w_round_exp, w_round_man[10:1]};
                end
            end else begin
                w_pack = {sign_r_q, exp_q, w_round_man[9:0]};
            end
`else
            w_pack = {sign_r_q, exp_q, sum_q[12:3]};
`endif
        end
    end

    // Next-state and datapath update for each FSM state
    always_comb begin
        state_d  = state_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sign_r_d = sign_r_q;
        exp_d    = exp_q;
        man_a_d  = man_a_q;
        man_b_d  = man_b_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (w_special) begin
                        result_d = w_special_res;
                        state_d  = DONE;
                    end else if (w_cancel) begin
                        result_d = 16'h0000;
                        state_d  = DONE;
                    end else begin
                        // On an exponent tie the operands keep their original order
                        sign_a_d = w_b_bigger ? b[15] : a[15];
                        sign_b_d = w_b_bigger ? a[15] : b[15];
                        exp_d    = w_b_bigger ? b[14:10] : a[14:10];
                        man_a_d  = w_b_bigger ? w_man_b : w_man_a;
                        man_b_d  = w_b_bigger ? w_man_a : w_man_b;
                        cnt_d    = w_cnt_ld;
                        state_d  = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (cnt_q != 4'd0) begin
                    man_b_d = {1'b0, man_b_q[13:2], man_b_q[1] | man_b_q[0]};
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (sign_a_q == sign_b_q) begin
                    sum_d    = {1'b0, man_a_q} + {1'b0, man_b_q};
                    sign_r_d = sign_a_q;
                end else if (man_a_q >= man_b_q) begin
                    sum_d    = {1'b0, man_a_q - man_b_q};
                    sign_r_d = sign_a_q;
                end else begin
                    sum_d    = {1'b0, man_b_q - man_a_q};
                    sign_r_d = sign_b_q;
                end
                state_d = NORM;
            end
            NORM: begin
                if (sum_q[14]) begin
                    sum_d = {1'b0, sum_q[14:2], sum_q[1] | sum_q[0]};
                    exp_d = exp_q + 5'd1;
                end else if (!sum_q[13] && (exp_q > 5'd1)) begin
                    sum_d = {sum_q[13:0], 1'b0};
                    exp_d = exp_q - 5'd1;
                end else begin
`ifdef FP16_ADD_SEQ_ROUND_EN
                    state_d = ROUND;
`else
                    result_d = w_pack;
                    state_d  = DONE;
`endif
                end
            end
`ifdef FP16_ADD_SEQ_ROUND_EN
            ROUND: begin
                result_d = w_pack;
                state_d  = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sign_r_q <= 1'b0;
            exp_q    <= 5'd0;
            man_a_q  <= 14'd0;
            man_b_q  <= 14'd0;
            cnt_q    <= 4'd0;
            sum_q    <= 15'd0;
            result_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sign_r_q <= sign_r_d;
            exp_q    <= exp_d;
            man_a_q  <= man_a_d;
            man_b_q  <= man_b_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

`default_nettype wire
